// File: rtl/tiny16_pkg.sv
// Shared definitions for the tiny16 control unit: widths, opcode constants,
// FSM state encoding, instruction field positions and small decode helpers.
package tiny16_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned REG_N  = 8;
    localparam int unsigned REG_AW = 3;
    localparam int unsigned IMM_W  = 8;
    localparam int unsigned MASK_W = 4;
    localparam int unsigned FLAG_W = 4;

    // Instruction field positions
    localparam int unsigned OP_MSB   = 15;
    localparam int unsigned OP_LSB   = 12;
    localparam int unsigned RD_MSB   = 11;
    localparam int unsigned RD_LSB   = 9;
    localparam int unsigned RS_MSB   = 8;
    localparam int unsigned RS_LSB   = 6;
    localparam int unsigned AR_BIT   = 5;
    localparam int unsigned IMM_MSB  = 7;
    localparam int unsigned IMM_LSB  = 0;
    localparam int unsigned MASK_MSB = 11;
    localparam int unsigned MASK_LSB = 8;

    // Opcodes
    localparam logic [OP_W-1:0] OP_NOP       = 4'h0;
    localparam logic [OP_W-1:0] OP_LOAD      = 4'h1;
    localparam logic [OP_W-1:0] OP_STORE     = 4'h2;
    localparam logic [OP_W-1:0] OP_ALU_FIRST = 4'h3;
    localparam logic [OP_W-1:0] OP_ALU_LAST  = 4'hB;
    localparam logic [OP_W-1:0] OP_LDI       = 4'hC;
    localparam logic [OP_W-1:0] OP_BR        = 4'hD;
    localparam logic [OP_W-1:0] OP_RSVD      = 4'hE;
    localparam logic [OP_W-1:0] OP_HALT      = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    // Memory bus command payload
    typedef struct packed {
        logic              req;
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    // ALU command payload
    typedef struct packed {
        logic              en;
        logic [OP_W-1:0]   opcode;
        logic              ar;
        logic [DATA_W-1:0] src1;
        logic [DATA_W-1:0] src2;
    } alu_cmd_t;

    function automatic logic [OP_W-1:0] f_op(input logic [DATA_W-1:0] ir);
        return ir[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [REG_AW-1:0] f_rd(input logic [DATA_W-1:0] ir);
        return ir[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [REG_AW-1:0] f_rs(input logic [DATA_W-1:0] ir);
        return ir[RS_MSB:RS_LSB];
    endfunction

    function automatic logic f_ar(input logic [DATA_W-1:0] ir);
        return ir[AR_BIT];
    endfunction

    function automatic logic [IMM_W-1:0] f_imm(input logic [DATA_W-1:0] ir);
        return ir[IMM_MSB:IMM_LSB];
    endfunction

    function automatic logic [MASK_W-1:0] f_mask(input logic [DATA_W-1:0] ir);
        return ir[MASK_MSB:MASK_LSB];
    endfunction

    function automatic logic is_alu(input logic [OP_W-1:0] op);
        return (op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST);
    endfunction

    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

    // Empty mask means unconditional; otherwise any selected flag set takes it.
    function automatic logic br_taken(input logic [MASK_W-1:0] mask,
                                      input logic [FLAG_W-1:0] flags);
        return (mask == '0) || ((mask & flags) != '0);
    endfunction

endpackage

// File: rtl/tiny16_regfile.sv
// tiny16 register file: 8 x 16-bit, two combinational read ports, one
// synchronous write port, synchronous clear on rst.
// Ports:
//   clk, rst            - clock, synchronous active-high clear
//   rd_addr/rd_data_c   - read port A (combinational)
//   rs_addr/rs_data_c   - read port B (combinational)
//   we, waddr, wdata    - write port, takes effect on rising edge
module tiny16_regfile
    import tiny16_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data_c,
    input  logic [REG_AW-1:0] rs_addr,
    output logic [DATA_W-1:0] rs_data_c,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs [REG_N];

    // Clear wins over a simultaneous write, so an aborted access leaves no trace.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_N); i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rd_data_c = regs[rd_addr];
    assign rs_data_c = regs[rs_addr];

endmodule

// File: rtl/control_unit.sv
// tiny16 multi-cycle control unit: fetches, decodes and executes one
// instruction at a time through FETCH/DECODE/EXECUTE/MEM, stops in HALT.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   mem_req/we/addr/wdata          - registered memory request, held until mem_ack
//   mem_rdata, mem_ack             - memory response
//   alu_opcode/ar_flag/src1/src2   - registered ALU command, live for one EXECUTE cycle
//   alu_out_en                     - ALU flag-update strobe
//   alu_out, alu_flags             - ALU result (combinational) and registered flags
//   halted                         - high while in HALT
module control_unit
    import tiny16_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [OP_W-1:0]   alu_opcode,
    output logic              alu_ar_flag,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    output logic              alu_out_en,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic              halted
);

    state_t            state, state_d;
    logic [DATA_W-1:0] pc, pc_d;
    logic [DATA_W-1:0] ir, ir_d;
    mem_cmd_t          mem_q, mem_d;
    alu_cmd_t          alu_q, alu_d;
    logic              halted_d;

    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rd, rs;
    logic [IMM_W-1:0]  imm;
    logic [MASK_W-1:0] mask;
    logic              ar;

    logic [DATA_W-1:0] rd_data, rs_data;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;

    // Instruction field decode
    assign op   = f_op(ir);
    assign rd   = f_rd(ir);
    assign rs   = f_rs(ir);
    assign imm  = f_imm(ir);
    assign mask = f_mask(ir);
    assign ar   = f_ar(ir);

    tiny16_regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd),
        .rd_data_c (rd_data),
        .rs_addr   (rs),
        .rs_data_c (rs_data),
        .we        (rf_we),
        .waddr     (rd),
        .wdata     (rf_wdata)
    );

    // State and registered-output update
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_FETCH;
            pc     <= RESET_PC;
            ir     <= '0;
            mem_q  <= '0;
            alu_q  <= '0;
            halted <= 1'b0;
        end else begin
            state  <= state_d;
            pc     <= pc_d;
            ir     <= ir_d;
            mem_q  <= mem_d;
            alu_q  <= alu_d;
            halted <= halted_d;
        end
    end

    // Next-state, next-output and register-write logic.
    // Outputs are computed for the state being entered, so they are registered
    // yet line up with the state they belong to.
    always_comb begin
        state_d  = state;
        pc_d     = pc;
        ir_d     = ir;
        mem_d    = '0;
        alu_d    = '0;
        rf_we    = 1'b0;
        rf_wdata = '0;
        halted_d = 1'b0;

        case (state)
            ST_FETCH: begin
                // Also covers the first cycle after reset, when no request is out yet.
                mem_d.req  = 1'b1;
                mem_d.addr = pc;
                if (mem_q.req && mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc + 16'd1;
                    state_d = ST_DECODE;
                    mem_d   = '0;
                end
            end

            ST_DECODE: begin
                state_d = ST_EXECUTE;
                if (is_alu(op)) begin
                    alu_d.en     = 1'b1;
                    alu_d.opcode = op;
                    alu_d.ar     = ar;
                    alu_d.src1   = rd_data;
                    alu_d.src2   = rs_data;
                end
            end

            ST_EXECUTE: begin
                state_d = ST_FETCH;
                if (is_alu(op)) begin
                    rf_we    = 1'b1;
                    rf_wdata = alu_out;
                end else begin
                    case (op)
                        OP_LDI: begin
                            rf_we    = 1'b1;
                            rf_wdata = DATA_W'(imm);
                        end
                        OP_BR: begin
                            if (br_taken(mask, alu_flags)) begin
                                pc_d = pc + sext_imm(imm);
                            end
                        end
                        OP_LOAD, OP_STORE: begin
                            state_d     = ST_MEM;
                            mem_d.req   = 1'b1;
                            mem_d.we    = (op == OP_STORE);
                            mem_d.addr  = rs_data;
                            mem_d.wdata = rd_data;
                        end
                        OP_HALT: begin
                            state_d = ST_HALT;
                        end
                        OP_NOP, OP_RSVD: begin
                            state_d = ST_FETCH;
                        end
                        default: begin
                            state_d = ST_FETCH;
                        end
                    endcase
                end
                // Launch the next fetch at the (possibly branched) PC.
                if (state_d == ST_FETCH) begin
                    mem_d.req  = 1'b1;
                    mem_d.addr = pc_d;
                end
            end

            ST_MEM: begin
                mem_d = mem_q;
                if (mem_q.req && mem_ack) begin
                    if (!mem_q.we) begin
                        rf_we    = 1'b1;
                        rf_wdata = mem_rdata;
                    end
                    state_d    = ST_FETCH;
                    mem_d      = '0;
                    mem_d.req  = 1'b1;
                    mem_d.addr = pc;
                end
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase

        halted_d = (state_d == ST_HALT);
    end

    assign mem_req     = mem_q.req;
    assign mem_we      = mem_q.we;
    assign mem_addr    = mem_q.addr;
    assign mem_wdata   = mem_q.wdata;
    assign alu_opcode  = alu_q.opcode;
    assign alu_ar_flag = alu_q.ar;
    assign alu_src1    = alu_q.src1;
    assign alu_src2    = alu_q.src2;
    assign alu_out_en  = alu_q.en;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a scoreboard queue holds the memory
// accesses the program should produce; each is popped and compared as the
// DUT issues it. A small ALU model supplies alu_out/alu_flags.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  alu_opcode, alu_flags;
    logic        alu_ar_flag, alu_out_en, halted;
    logic [15:0] alu_src1, alu_src2, alu_out;

    // Second instance for the RESET_PC wrap case
    logic        rst2 = 1'b1;
    logic        mem2_req, mem2_we, mem2_ack;
    logic [15:0] mem2_addr, mem2_wdata, mem2_rdata;
    logic [3:0]  alu2_opcode;
    logic [3:0]  alu2_flags = 4'h0;
    logic        alu2_ar_flag, alu2_out_en, halted2;
    logic [15:0] alu2_src1, alu2_src2;
    logic [15:0] alu2_out = 16'h0000;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        string       name;
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          delay;
    } acc_t;

    acc_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    control_unit #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .alu_opcode(alu_opcode), .alu_ar_flag(alu_ar_flag),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_out_en(alu_out_en),
        .alu_out(alu_out), .alu_flags(alu_flags), .halted(halted)
    );

    control_unit #(.RESET_PC(16'hFFFF)) dut2 (
        .clk(clk), .rst(rst2),
        .mem_req(mem2_req), .mem_we(mem2_we), .mem_addr(mem2_addr),
        .mem_wdata(mem2_wdata), .mem_rdata(mem2_rdata), .mem_ack(mem2_ack),
        .alu_opcode(alu2_opcode), .alu_ar_flag(alu2_ar_flag),
        .alu_src1(alu2_src1), .alu_src2(alu2_src2), .alu_out_en(alu2_out_en),
        .alu_out(alu2_out), .alu_flags(alu2_flags), .halted(halted2)
    );

    // ALU model: result combinational, flags {O,C,N,Z} registered on the strobe
    function automatic logic [15:0] alu_model(input logic [3:0] op,
                                              input logic [15:0] a,
                                              input logic [15:0] b);
        case (op)
            4'h3:    return a + b;
            4'h4:    return a - b;
            4'h5:    return a & b;
            4'h6:    return a | b;
            4'h7:    return a ^ b;
            default: return a;
        endcase
    endfunction

    assign alu_out = alu_model(alu_opcode, alu_src1, alu_src2);

    always @(posedge clk) begin
        if (rst)             alu_flags <= 4'h0;
        else if (alu_out_en) alu_flags <= {2'b00, alu_out[15], (alu_out == 16'h0000)};
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input string name, input logic [15:0] addr, input logic we,
                        input logic [15:0] wdata, input logic [15:0] rdata, input int delay);
        acc_t e;
        e.name = name; e.addr = addr; e.we = we;
        e.wdata = wdata; e.rdata = rdata; e.delay = delay;
        exp_q.push_back(e);
    endtask

    // Wait for the next request, compare against the scoreboard head, hold it
    // for the entry's wait cycles, then ack. Returns at the negedge after ack.
    task automatic serve_next(output int seen);
        acc_t e;
        int   n;
        seen = -1;
        e = exp_q.pop_front();
        n = 0;
        while (mem_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({e.name, "_req"}, 16'(mem_req), 16'd1);
        if (mem_req !== 1'b1) return;
        seen = cyc;
        chk({e.name, "_addr"}, mem_addr, e.addr);
        chk({e.name, "_we"}, 16'(mem_we), 16'(e.we));
        if (e.we) chk({e.name, "_wdata"}, mem_wdata, e.wdata);
        repeat (e.delay) begin
            @(negedge clk);
            chk({e.name, "_hold_req"}, 16'(mem_req), 16'd1);
            chk({e.name, "_hold_addr"}, mem_addr, e.addr);
            chk({e.name, "_hold_we"}, 16'(mem_we), 16'(e.we));
            if (e.we) chk({e.name, "_hold_wdata"}, mem_wdata, e.wdata);
        end
        mem_rdata = e.rdata;
        mem_ack   = 1'b1;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
    endtask

    task automatic serve_all();
        int s;
        while (exp_q.size() > 0) serve_next(s);
    endtask

    task automatic pulse_reset();
        mem_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int c0, c3, s, n;
        mem_ack    = 1'b0;
        mem_rdata  = 16'hDEAD;
        mem2_ack   = 1'b0;
        mem2_rdata = 16'h0000;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_req", 16'(mem_req), 16'd0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_halted", 16'(halted), 16'd0);
        chk("rst_alu_en", 16'(alu_out_en), 16'd0);
        chk("rst_alu_src1", alu_src1, 16'h0000);
        rst = 1'b0;

        // LDI r1,5; LDI r2,3; ADD r1,r2
        push("f0", 16'h0000, 1'b0, 16'h0, 16'hC205, 0);
        push("f1", 16'h0001, 1'b0, 16'h0, 16'hC403, 0);
        push("f2", 16'h0002, 1'b0, 16'h0, 16'h3280, 0);
        serve_next(c0);
        serve_next(s);
        serve_next(s);
        chk("add_decode_alu_en", 16'(alu_out_en), 16'd0);
        chk("add_decode_req", 16'(mem_req), 16'd0);
        @(negedge clk);
        chk("add_opcode", 16'(alu_opcode), 16'd3);
        chk("add_src1", alu_src1, 16'd5);
        chk("add_src2", alu_src2, 16'd3);
        chk("add_alu_en", 16'(alu_out_en), 16'd1);
        chk("add_ar", 16'(alu_ar_flag), 16'd0);
        // STORE r1,[r0] exposes R1; then HALT
        push("f3", 16'h0003, 1'b0, 16'h0, 16'h2200, 0);
        push("st_r1", 16'h0000, 1'b1, 16'd8, 16'h0, 0);
        push("f4", 16'h0004, 1'b0, 16'h0, 16'hF000, 0);
        serve_next(c3);
        chk("add_latency", 16'(c3 - c0), 16'd9);
        @(negedge clk);
        chk("exec_alu_en_after", 16'(alu_out_en), 16'd0);
        serve_next(s);
        serve_next(s);
        repeat (2) @(negedge clk);
        mem_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("halt_halted", 16'(halted), 16'd1);
            chk("halt_no_req", 16'(mem_req), 16'd0);
            @(negedge clk);
        end
        pulse_reset();
        chk("halt_rst_halted", 16'(halted), 16'd0);
        chk("halt_rst_req", 16'(mem_req), 16'd0);

        // Branch tests: taken Z, not-taken N, unconditional backward
        push("b0", 16'h0000, 1'b0, 16'h0, 16'hC203, 0);
        push("b1", 16'h0001, 1'b0, 16'h0, 16'hC403, 0);
        push("b2", 16'h0002, 1'b0, 16'h0, 16'h0000, 0);
        push("b3", 16'h0003, 1'b0, 16'h0, 16'h4280, 0);
        push("b4", 16'h0004, 1'b0, 16'h0, 16'hD102, 0);
        push("b7", 16'h0007, 1'b0, 16'h0, 16'hD205, 0);
        push("b8", 16'h0008, 1'b0, 16'h0, 16'hD0FC, 0);
        push("b5", 16'h0005, 1'b0, 16'h0, 16'hF000, 0);
        serve_all();
        repeat (2) @(negedge clk);
        pulse_reset();

        // STORE with a 3-cycle ack delay, then LOAD aborted by reset
        push("s0", 16'h0000, 1'b0, 16'h0, 16'hC207, 0);
        push("s1", 16'h0001, 1'b0, 16'h0, 16'hC440, 0);
        push("s2", 16'h0002, 1'b0, 16'h0, 16'h2280, 0);
        push("st_slow", 16'h0040, 1'b1, 16'd7, 16'h0, 3);
        push("s3", 16'h0003, 1'b0, 16'h0, 16'h1680, 0);
        serve_all();
        n = 0;
        while (mem_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ld_req", 16'(mem_req), 16'd1);
        chk("ld_addr", mem_addr, 16'h0040);
        chk("ld_we", 16'(mem_we), 16'd0);
        repeat (2) @(negedge clk);
        rst       = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        @(negedge clk);
        rst       = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
        chk("ld_abort_req", 16'(mem_req), 16'd0);
        chk("ld_abort_halted", 16'(halted), 16'd0);
        // R3 must not have taken the aborted load; R1 cleared by reset
        push("a0", 16'h0000, 1'b0, 16'h0, 16'h2600, 0);
        push("st_r3", 16'h0000, 1'b1, 16'h0000, 16'h0, 0);
        push("a1", 16'h0001, 1'b0, 16'h0, 16'h2200, 0);
        push("st_r1z", 16'h0000, 1'b1, 16'h0000, 16'h0, 0);
        push("a2", 16'h0002, 1'b0, 16'h0, 16'hF000, 0);
        serve_all();

        // RESET_PC = FFFF: NOP at FFFF, next fetch wraps to 0000
        rst2 = 1'b0;
        n = 0;
        while (mem2_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("wrap_req0", 16'(mem2_req), 16'd1);
        chk("wrap_addr0", mem2_addr, 16'hFFFF);
        mem2_rdata = 16'h0000;
        mem2_ack   = 1'b1;
        @(negedge clk);
        mem2_ack   = 1'b0;
        n = 0;
        while (mem2_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("wrap_req1", 16'(mem2_req), 16'd1);
        chk("wrap_addr1", mem2_addr, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port mem_req  output  1  memory request, held until mem_ack.
REQ-005 SHALL have port mem_we  output  1  1 = write, 0 = read; valid with mem_req.
REQ-006 SHALL have port mem_addr  output  16  word address; valid with mem_req.
REQ-007 SHALL have port mem_wdata  output  16  store data; valid when mem_req and mem_we are both high.
REQ-008 SHALL have port mem_rdata  input  16  read data; sampled in the cycle mem_ack is high.
REQ-009 SHALL have port mem_ack  input  1  completes request; may rise in the same cycle as mem_req.
REQ-010 SHALL have port alu_opcode  output  4  ALU operation code.
REQ-011 SHALL have port alu_ar_flag  output  1  arithmetic or rotate shift select.
REQ-012 SHALL have port alu_src1, alu_src2  output  16 each  ALU operands.
REQ-013 SHALL have port alu_out_en  output  1  ALU flag-update strobe.
REQ-014 SHALL have port alu_out  input  16  ALU result; combinational from the operands.
REQ-015 SHALL have port alu_flags  input  4  registered {O,C,N,Z} from the ALU.
REQ-016 SHALL have port halted  output  1  high while in state HALT.

Function
REQ-017 Instruction fields: [15:12] op, [11:9] rd, [8:6] rs, [5] ar, [7:0] imm8, [11:8] cond mask.
REQ-018 Opcodes: 0000 NOP; 0001 LOAD rd<-mem[R[rs]]; 0010 STORE mem[R[rs]]<-R[rd]; 0011-1011 ALU; 1100 LDI rd<-{8'h00,imm8}; 1101 BR; 1110 reserved, executes as NOP; 1111 HALT.
REQ-019 States: FETCH, DECODE, EXECUTE, MEM, HALT.
REQ-020 FETCH: mem_req=1, mem_we=0, mem_addr=PC. On mem_ack: IR<=mem_rdata, PC<=PC+1 (16'hFFFF wraps to 0), go to DECODE.
REQ-021 DECODE: one cycle, no outputs active, go to EXECUTE.
REQ-022 EXECUTE, ALU op: for exactly one cycle drive alu_opcode=op, alu_ar_flag=ar, alu_src1=R[rd], alu_src2=R[rs], alu_out_en=1; R[rd]<=alu_out; go to FETCH.
REQ-023 EXECUTE, LDI/NOP/reserved: perform write (LDI only), go to FETCH.
REQ-024 EXECUTE, BR: branch taken when mask==0 or (mask & alu_flags)!=0.
REQ-025 Taken BR: PC<=PC+sign-extended imm8, where PC is already incremented; go to FETCH.
REQ-026 EXECUTE, LOAD/STORE: go to MEM.
REQ-027 EXECUTE, HALT: go to HALT.
REQ-028 MEM: mem_req=1, mem_addr=R[rs], mem_we=(op==STORE), mem_wdata=R[rd].
REQ-029 MEM on mem_ack: LOAD writes R[rd]<=mem_rdata; go to FETCH.
REQ-030 mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable from assertion until the ack cycle.
REQ-031 mem_ack while mem_req=0 SHALL be ignored.
REQ-032 Outside EXECUTE-ALU: alu_opcode=0, alu_ar_flag=0, alu_src1=0, alu_src2=0, alu_out_en=0.
REQ-033 HALT SHALL be absorbing: mem_req=0, halted=1, state left only by rst.
REQ-034 Latency with zero-wait memory: ALU/LDI/BR/NOP take 3 cycles; LOAD/STORE take 4 cycles.
REQ-035 Register r0 is an ordinary writable register.

Reset
REQ-036 rst SHALL force: state=FETCH, PC=RESET_PC, IR=0, R0..R7=0, halted=0, all outputs 0.
REQ-037 rst SHALL win over every simultaneous event, including mem_ack and HALT.
REQ-038 rst during MEM or FETCH wait SHALL drop mem_req in the following cycle.
REQ-039 The aborted access SHALL cause no register write.

Structure
REQ-040 Package tiny16_pkg SHALL hold opcode constants, state encoding, and instruction field positions.
REQ-041 Sub-module tiny16_regfile: 8x16, 2 combinational read ports, 1 synchronous write port, synchronous clear.

Verification
REQ-042 LDI r1,5 (C205); LDI r2,3 (C403); ADD r1,r2 (3280), zero-wait -> ADD cycle shows alu_opcode=3, src1=5, src2=3, alu_out_en pulse; R1=8; 9 cycles total.
REQ-043 r1=r2=3; SUB r1,r2 (4280); BR Z,+2 (D102) at addr 4 -> Z=1, next fetch mem_addr=7.
REQ-044 STORE with mem_ack delayed 3 cycles -> req/addr/wdata constant for 3 cycles; exactly one write; next FETCH follows.
REQ-045 HALT (F000) -> halted=1 and no mem_req for 20 cycles; one-cycle rst -> fetch at RESET_PC.
REQ-046 rst asserted in MEM wait of LOAD -> next cycle mem_req=0, PC=RESET_PC, destination register stays 0.
REQ-047 RESET_PC=16'hFFFF, NOP there -> next fetch mem_addr=16'h0000.
